ex2mem_pipe_stage: RTL

- Parametrised EX->MEM pipeline stage register; next generation of the fixed 16-bit EX/MEM latch.
- Carries control word, Read1 operand, ALU/memory result and destination register index from EX to MEM.
- Adds a valid/ready handshake with a 2-entry skid buffer so MEM back-pressure never drops a beat.
- Adds flush, special-change field hold and a saturating stall counter.

---
 rtl/ex2mem_pipe_stage_if.sv | 32 +++
 rtl/ex2mem_pipe_stage.sv | 132 +++++++++++++
 2 files changed

// File: rtl/ex2mem_pipe_stage_if.sv
// EX->MEM stage bus: beat payload in both directions plus valid/ready, flush and special_change.
// master = EX/MEM environment, slave = the pipeline stage.
interface ex2mem_pipe_stage_if #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_W   = 4
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              special_change;
  logic [CTRL_W-1:0] ctrl_in;
  logic [DATA_W-1:0] read1_in;
  logic [DATA_W-1:0] aluormem_in;
  logic [RD_W-1:0]   rd_in;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] ctrl_out;
  logic [DATA_W-1:0] read1_out;
  logic [DATA_W-1:0] aluormem_out;
  logic [RD_W-1:0]   rd_out;

  modport master (
    output flush, in_valid, special_change, ctrl_in, read1_in, aluormem_in, rd_in, out_ready,
    input  in_ready, out_valid, ctrl_out, read1_out, aluormem_out, rd_out
  );

  modport slave (
    input  flush, in_valid, special_change, ctrl_in, read1_in, aluormem_in, rd_in, out_ready,
    output in_ready, out_valid, ctrl_out, read1_out, aluormem_out, rd_out
  );
endinterface

// File: rtl/ex2mem_pipe_stage.sv
// EX->MEM pipeline register with 2-entry skid buffer, flush, special-change hold and stall counter.
// Optional macro EX2MEM_FWD_EN adds the fwd_valid/fwd_rd/fwd_data forwarding outputs.
module ex2mem_pipe_stage #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_W   = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rest,
  ex2mem_pipe_stage_if.slave  bus,
  output logic [CNT_W-1:0]    stall_cnt
`ifdef EX2MEM_FWD_EN
  ,
  output logic                fwd_valid,
  output logic [RD_W-1:0]     fwd_rd,
  output logic [DATA_W-1:0]   fwd_data
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] read1;
    logic [DATA_W-1:0] aluormem;
    logic [RD_W-1:0]   rd;
  } beat_t;

  beat_t             or_q, or_d, sk_q, sk_d, new_beat;
  logic              or_vld_q, or_vld_d, sk_vld_q, sk_vld_d;
  logic              in_ready_q;
  logic [CTRL_W-1:0] ctrl_out_q;
  logic [DATA_W-1:0] last_read1_q, last_read1_d;
  logic [RD_W-1:0]   last_rd_q, last_rd_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              accept, drain;

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = or_vld_q & bus.out_ready;

  // special_change keeps the previous Read1/Rd but takes the new Ctrl/AluOrMem
  always_comb begin
    new_beat.ctrl     = bus.ctrl_in;
    new_beat.aluormem = bus.aluormem_in;
    new_beat.read1    = bus.special_change ? last_read1_q : bus.read1_in;
    new_beat.rd       = bus.special_change ? last_rd_q : bus.rd_in;
  end

  always_comb begin
    or_d         = or_q;
    or_vld_d     = or_vld_q;
    sk_d         = sk_q;
    sk_vld_d     = sk_vld_q;
    last_read1_d = last_read1_q;
    last_rd_d    = last_rd_q;
    stall_cnt_d  = stall_cnt_q;

    // OR free or draining: refill from SK first to keep FIFO order, else from input
    if (!or_vld_q || drain) begin
      if (sk_vld_q) begin
        or_d     = sk_q;
        or_vld_d = 1'b1;
        sk_vld_d = 1'b0;
      end else if (accept) begin
        or_d     = new_beat;
        or_vld_d = 1'b1;
      end else begin
        or_vld_d = 1'b0;
      end
    end else if (accept) begin
      sk_d     = new_beat;
      sk_vld_d = 1'b1;
    end

    if (accept && !bus.special_change) begin
      last_read1_d = bus.read1_in;
      last_rd_d    = bus.rd_in;
    end

    // flush kills everything but leaves the visible data fields holding their old values
    if (bus.flush) begin
      or_d     = or_q;
      sk_d     = sk_q;
      or_vld_d = 1'b0;
      sk_vld_d = 1'b0;
    end

    if (or_vld_q && !bus.out_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rest) begin
      or_q         <= '0;
      sk_q         <= '0;
      or_vld_q     <= 1'b0;
      sk_vld_q     <= 1'b0;
      in_ready_q   <= 1'b1;
      ctrl_out_q   <= '0;
      last_read1_q <= '0;
      last_rd_q    <= '0;
      stall_cnt_q  <= '0;
    end else begin
      or_q         <= or_d;
      sk_q         <= sk_d;
      or_vld_q     <= or_vld_d;
      sk_vld_q     <= sk_vld_d;
      in_ready_q   <= ~sk_vld_d;
      ctrl_out_q   <= or_vld_d ? or_d.ctrl : '0;
      last_read1_q <= last_read1_d;
      last_rd_q    <= last_rd_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = or_vld_q;
  assign bus.ctrl_out     = ctrl_out_q;
  assign bus.read1_out    = or_q.read1;
  assign bus.aluormem_out = or_q.aluormem;
  assign bus.rd_out       = or_q.rd;
  assign stall_cnt        = stall_cnt_q;

`ifdef EX2MEM_FWD_EN
  assign fwd_valid = or_vld_q & ctrl_out_q[0];
  assign fwd_rd    = or_q.rd;
  assign fwd_data  = or_q.aluormem;
`endif

endmodule
